// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encoding and CRC constants.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } ccff_state_t;

    // CRC-16-CCITT, MSB-first bit-serial form
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear and enable.
// Latency: one bit folded in per enabled clock edge; crc reflects it the following cycle.
// Backpressure: none; the caller gates accumulation with en.
module ccff_crc16
    import ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic        fb;
    logic [15:0] crc_next;

    // One LFSR step: feedback is the outgoing MSB xor the incoming data bit
    always_comb begin
        fb       = crc[15] ^ din;
        crc_next = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end

    // Clear wins over enable so a new load always starts from the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Loads a serial configuration chain from a word-wide bitstream, LSB first; optional readback CRC under CCFF_LOADER_READBACK_EN.
// Latency: first chain_en the cycle after the first word transfer; CHAIN_LEN shift cycles plus word stalls per load.
// Backpressure: wr_ready only in WAIT_WORD; wr_valid gaps stall the chain (chain_en low) without losing position.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 18,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef CCFF_LOADER_READBACK_EN
    ,
    output logic [15:0]       readback_crc
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = $clog2(WORD_W + 1);

    // Values the counters hold during the final shift of the chain / of a word
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    ccff_state_t       state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [WORD_W-1:0] shreg;

    logic in_load;
    logic accept_start;
    logic do_abort;
    logic word_xfer;

    always_comb begin
        in_load      = (state == ST_WAIT_WORD) || (state == ST_SHIFT);
        accept_start = (state == ST_IDLE) && start;
        do_abort     = in_load && abort;
        // abort outranks a word arriving in the same cycle
        word_xfer    = (state == ST_WAIT_WORD) && wr_valid && !abort;
    end

    // State register
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: chain length is checked before word length so a short final word ends the load
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_WAIT_WORD;
            end
            ST_WAIT_WORD: begin
                if (abort)         state_next = ST_IDLE;
                else if (wr_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort)                   state_next = ST_IDLE;
                else if (bit_cnt == CNT_LAST) state_next = ST_DONE;
                else if (bit_idx == IDX_LAST) state_next = ST_WAIT_WORD;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state and the registered shift register
    always_comb begin
        chain_en  = (state == ST_SHIFT);
        ccff_head = (state == ST_SHIFT) && shreg[0];
        wr_ready  = (state == ST_WAIT_WORD);
        busy      = in_load;
        done      = (state == ST_DONE);
    end

    // Datapath: word capture, LSB-first shift-out, chain/word position counters, sticky abort flag
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            aborted <= 1'b0;
        end else begin
            if (accept_start) begin
                bit_cnt <= '0;
                aborted <= 1'b0;
            end
            if (word_xfer) begin
                shreg   <= wr_data;
                bit_idx <= '0;
            end
            if (state == ST_SHIFT) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 1'b1;
                bit_idx <= bit_idx + 1'b1;
            end
            if (do_abort) begin
                aborted <= 1'b1;
            end
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    // Tail bits are folded in on exactly the edges where the chain shifts
    ccff_crc16 u_crc (
        .clk   (prog_clk),
        .rst_n (prog_reset_n),
        .clr   (accept_start),
        .en    (state == ST_SHIFT),
        .din   (ccff_tail),
        .crc   (readback_crc)
    );
`else
    // Tail is only observed by the readback CRC
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: stimulus queues expected head bits and final chain images,
// a negedge monitor pops them as chain_en / done appear.
// Directed checks cover reset, gaps, abort, start-while-busy and mid-shift reset.
module tb_ccff_loader;

    localparam int CHAIN_LEN = 18;
    localparam int WORD_W    = 8;

    logic              prog_clk     = 1'b0;
    logic              prog_reset_n = 1'b0;
    logic              start        = 1'b0;
    logic              abort        = 1'b0;
    logic              wr_valid     = 1'b0;
    logic [WORD_W-1:0] wr_data      = '0;
    logic              wr_ready;
    logic              ccff_head;
    logic              chain_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              aborted;
`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0]       readback_crc;
`endif

    // Model of the physical chain: head enters at the top, tail is bit 0
    logic [CHAIN_LEN-1:0] chain_model = '0;
    logic                 preload     = 1'b0;
    assign ccff_tail = chain_model[0];

    bit                   exp_bits[$];
    logic [CHAIN_LEN-1:0] exp_done[$];
    int                   n_vec  = 0;
    int                   n_miss = 0;

    ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .abort        (abort),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .ccff_head    (ccff_head),
        .chain_en     (chain_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
`ifdef CCFF_LOADER_READBACK_EN
        ,
        .readback_crc (readback_crc)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (preload)       chain_model <= '1;
        else if (chain_en) chain_model <= {ccff_head, chain_model[CHAIN_LEN-1:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event occurred that should not have", name);
    endtask

    // Monitor: every chain_en cycle consumes one expected head bit; every done consumes one chain image
    initial begin : monitor
        int   en_cnt;
        logic prev_done;
        logic [CHAIN_LEN-1:0] e;
        en_cnt    = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (chain_en) begin
                en_cnt++;
                if (exp_bits.size() == 0) flag("unexpected_shift");
                else check("head_bit", {31'd0, ccff_head}, {31'd0, exp_bits.pop_front()});
            end
            if (done) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (exp_done.size() == 0) flag("unexpected_done");
                else begin
                    e = exp_done.pop_front();
                    check("chain_image", 32'(chain_model), 32'(e));
                    check("chain_en_count", en_cnt, CHAIN_LEN);
                    check("bits_left_unshifted", exp_bits.size(), 0);
                end
            end
            if (!busy) en_cnt = 0;
            prev_done = done;
        end
    end

    // All callers sit at posedge+1
    task automatic start_load();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("start_busy_ready_aborted", {29'd0, busy, wr_ready, aborted}, 32'b110);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input int nbits);
        bit got;
        for (int i = 0; i < nbits; i++) exp_bits.push_back(d[i]);
        wr_data  = d;
        wr_valid = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge prog_clk);
            if (wr_ready) got = 1'b1;
        end
        if (!got) flag("wr_ready_timeout");
        @(posedge prog_clk); #1;
        wr_valid = 1'b0;
        wr_data  = '0;
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge prog_clk);
            if (!busy && !done) got = 1'b1;
        end
        if (!got) flag("idle_timeout");
        @(posedge prog_clk); #1;
    endtask

    // Idle out most of a 5+ cycle gap, confirming the chain is stalled while waiting
    task automatic gap_wait();
        repeat (11) @(posedge prog_clk);
        @(negedge prog_clk);
        check("gap_chain_en_wr_ready", {30'd0, chain_en, wr_ready}, 32'b01);
        @(posedge prog_clk); #1;
    endtask

    task automatic full_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                             input logic [WORD_W-1:0] w2, input logic [CHAIN_LEN-1:0] img,
                             input bit gaps, input bit start_mid);
        exp_done.push_back(img);
        start_load();
        send_word(w0, WORD_W);
        if (gaps) gap_wait();
        send_word(w1, WORD_W);
        if (start_mid) begin
            start = 1'b1;
            @(posedge prog_clk); #1;
            start = 1'b0;
            check("start_mid_busy", {31'd0, busy}, 32'd1);
        end
        if (gaps) gap_wait();
        send_word(w2, CHAIN_LEN - 2 * WORD_W);
        wait_idle();
        check("post_load_idle", {28'd0, busy, wr_ready, chain_en, done}, 32'd0);
        check("post_load_queue", exp_done.size(), 0);
    endtask

`ifdef CCFF_LOADER_READBACK_EN
    function automatic logic [15:0] crc_ones(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ 1'b1;
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    initial begin : stim
        #2;
        check("reset_outputs", {26'd0, chain_en, ccff_head, wr_ready, busy, done, aborted}, 32'd0);
        @(posedge prog_clk); #1;
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;

        // Back-to-back words; upper 6 bits of 0x02 never reach the chain
        full_load(8'hA5, 8'h3C, 8'h02, 18'h23CA5, 1'b0, 1'b0);
        // Same load with gaps between words
        full_load(8'hA5, 8'h3C, 8'h02, 18'h23CA5, 1'b1, 1'b0);
        // Start pulse mid-load must not disturb the count
        full_load(8'hFF, 8'h00, 8'h01, 18'h100FF, 1'b0, 1'b1);

        // Abort on the 4th shift of word 2
        start_load();
        send_word(8'h5A, WORD_W);
        send_word(8'hC3, 4);
        repeat (3) @(posedge prog_clk);
        #1 abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        check("abort_state", {27'd0, chain_en, wr_ready, busy, done, aborted}, 32'b00001);
        repeat (3) @(posedge prog_clk); #1;
        check("abort_sticky", {31'd0, aborted}, 32'd1);
        check("abort_bits_consumed", exp_bits.size(), 0);

        // Abort while idle is ignored
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        check("idle_abort_ignored", {30'd0, busy, aborted}, 32'b01);

        // Next load clears aborted (checked in start_load) and completes normally
        full_load(8'h5A, 8'hC3, 8'hFE, 18'h2C35A, 1'b0, 1'b0);

        // Reset in the middle of shifting the first word
        start_load();
        send_word(8'hC3, 3);
        repeat (3) @(negedge prog_clk);
        #1 prog_reset_n = 1'b0;
        #1;
        check("reset_mid_shift", {26'd0, chain_en, ccff_head, wr_ready, busy, done, aborted}, 32'd0);
        @(posedge prog_clk); #1;
        check("reset_held", {26'd0, chain_en, ccff_head, wr_ready, busy, done, aborted}, 32'd0);
        prog_reset_n = 1'b1;
        check("reset_bits_consumed", exp_bits.size(), 0);
        @(posedge prog_clk); #1;
        full_load(8'hA5, 8'h3C, 8'h02, 18'h23CA5, 1'b0, 1'b0);

`ifdef CCFF_LOADER_READBACK_EN
        preload = 1'b1;
        @(posedge prog_clk); #1;
        preload = 1'b0;
        full_load(8'hA5, 8'h3C, 8'h02, 18'h23CA5, 1'b0, 1'b0);
        check("readback_crc", {16'd0, readback_crc}, {16'd0, crc_ones(CHAIN_LEN)});
`endif

        repeat (3) @(posedge prog_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
